// File: rtl/bus_arbiter.sv
// Two-master fixed-priority bus arbiter; after granting, it shifts in the owner's
// serial slave address MSB first. Every output is registered from next-state logic.
module bus_arbiter #(
    parameter int SLAVE_ADDR_W = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    m1_request,
    input  logic                    m2_request,
    input  logic                    m1_slave_sel,
    input  logic                    m2_slave_sel,
    output logic                    m1_grant,
    output logic                    m2_grant,
    output logic [1:0]              bus_grant,
    output logic [SLAVE_ADDR_W-1:0] slave_sel
);

    localparam int CNT_W = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLAVE_ADDR_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        M1_ADDR,
        M2_ADDR,
        M1_BUSY,
        M2_BUSY
    } state_t;

    state_t                  state, state_nxt;
    logic [SLAVE_ADDR_W-1:0] shift_q, shift_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_nxt;
    logic [SLAVE_ADDR_W-1:0] sel_nxt;
    logic                    m1_grant_nxt, m2_grant_nxt;
    logic                    owner_request;
    logic                    owner_bit;
    logic [SLAVE_ADDR_W:0]   shifted;

    // The owner's request and address bit; the other master's inputs never reach the datapath.
    assign owner_request = (state == M1_ADDR || state == M1_BUSY) ? m1_request : m2_request;
    assign owner_bit     = (state == M2_ADDR) ? m2_slave_sel : m1_slave_sel;
    assign shifted       = {shift_q, owner_bit};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        sel_nxt   = slave_sel;
        unique case (state)
            IDLE: begin
                shift_nxt = '0;
                cnt_nxt   = '0;
                sel_nxt   = '0;
                if (m1_request)      state_nxt = M1_ADDR;
                else if (m2_request) state_nxt = M2_ADDR;
            end
            M1_ADDR, M2_ADDR: begin
                if (!owner_request) begin
                    // Dropping the request mid-address discards the partial address.
                    state_nxt = IDLE;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                end else begin
                    shift_nxt = shifted[SLAVE_ADDR_W-1:0];
                    if (cnt_q == LAST_BIT) begin
                        sel_nxt   = shifted[SLAVE_ADDR_W-1:0];
                        cnt_nxt   = '0;
                        state_nxt = (state == M1_ADDR) ? M1_BUSY : M2_BUSY;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            M1_BUSY, M2_BUSY: begin
                if (!owner_request) begin
                    state_nxt = IDLE;
                    shift_nxt = '0;
                    sel_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                shift_nxt = '0;
                cnt_nxt   = '0;
                sel_nxt   = '0;
            end
        endcase
    end

    assign m1_grant_nxt = (state_nxt == M1_ADDR) || (state_nxt == M1_BUSY);
    assign m2_grant_nxt = (state_nxt == M2_ADDR) || (state_nxt == M2_BUSY);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            slave_sel <= '0;
            m1_grant  <= 1'b0;
            m2_grant  <= 1'b0;
            bus_grant <= 2'b00;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            cnt_q     <= cnt_nxt;
            slave_sel <= sel_nxt;
            m1_grant  <= m1_grant_nxt;
            m2_grant  <= m2_grant_nxt;
            bus_grant <= {m2_grant_nxt, m1_grant_nxt};
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each task drives one scenario and compares the packed
// output vector {m1_grant, m2_grant, bus_grant, slave_sel} against hand-derived values.
module tb_bus_arbiter;

    logic       sys_clk;
    logic       sys_rst;
    logic       m1_request, m2_request;
    logic       m1_slave_sel, m2_slave_sel;
    logic       m1_grant, m2_grant;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;
    logic [5:0] outs;
    int         checks;
    int         errors;

    bus_arbiter #(.SLAVE_ADDR_W(2)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .m1_request  (m1_request),
        .m2_request  (m2_request),
        .m1_slave_sel(m1_slave_sel),
        .m2_slave_sel(m2_slave_sel),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .bus_grant   (bus_grant),
        .slave_sel   (slave_sel)
    );

    assign outs = {m1_grant, m2_grant, bus_grant, slave_sel};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst    = 1'b0;
        m1_request = 1'b1;
        m2_request = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 6'b00_00_00);
        end
        sys_rst = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL reset_release_m1_grant: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_request = 1'b0;
        m2_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL reset_release_drop: got %b expected %b", outs, 6'b00_00_00);
        end
    endtask

    task automatic test_m1_single();
        m1_request = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL m1_grant_edge: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_slave_sel = 1'b1;
        m2_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL m1_first_addr_bit: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_slave_sel = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b10_01_10) begin
            errors++;
            $display("FAIL m1_slave_sel_loaded: got %b expected %b", outs, 6'b10_01_10);
        end
        m1_slave_sel = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 6'b10_01_10) begin
            errors++;
            $display("FAIL m1_slave_sel_held: got %b expected %b", outs, 6'b10_01_10);
        end
        m1_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL m1_release: got %b expected %b", outs, 6'b00_00_00);
        end
    endtask

    task automatic test_m2_single();
        m2_request   = 1'b1;
        m1_slave_sel = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b01_10_00) begin
            errors++;
            $display("FAIL m2_grant_edge: got %b expected %b", outs, 6'b01_10_00);
        end
        m2_slave_sel = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 6'b01_10_11) begin
            errors++;
            $display("FAIL m2_slave_sel_loaded: got %b expected %b", outs, 6'b01_10_11);
        end
        m2_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL m2_release: got %b expected %b", outs, 6'b00_00_00);
        end
    endtask

    task automatic test_simultaneous();
        m1_request   = 1'b1;
        m2_request   = 1'b1;
        m2_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL simul_m1_priority: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_slave_sel = 1'b0;
        tick();
        m1_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_01) begin
            errors++;
            $display("FAIL simul_m1_addr: got %b expected %b", outs, 6'b10_01_01);
        end
        m1_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL simul_idle_turnaround: got %b expected %b", outs, 6'b00_00_00);
        end
        tick();
        checks++;
        if (outs !== 6'b01_10_00) begin
            errors++;
            $display("FAIL simul_m2_granted: got %b expected %b", outs, 6'b01_10_00);
        end
        m2_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL simul_m2_release: got %b expected %b", outs, 6'b00_00_00);
        end
    endtask

    task automatic test_no_preemption();
        m2_request   = 1'b1;
        tick();
        m2_slave_sel = 1'b0;
        tick();
        m2_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b01_10_01) begin
            errors++;
            $display("FAIL nopre_m2_busy: got %b expected %b", outs, 6'b01_10_01);
        end
        m1_request = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 6'b01_10_01) begin
            errors++;
            $display("FAIL nopre_m2_kept: got %b expected %b", outs, 6'b01_10_01);
        end
        m2_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL nopre_idle_turnaround: got %b expected %b", outs, 6'b00_00_00);
        end
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL nopre_m1_granted: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_request = 1'b0;
        tick();
    endtask

    task automatic test_abort_addr();
        m1_request   = 1'b1;
        tick();
        m1_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL abort_partial_addr: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_request = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL abort_addr_idle: got %b expected %b", outs, 6'b00_00_00);
        end
        // A fresh transaction must assemble its address from scratch.
        m1_request   = 1'b1;
        tick();
        m1_slave_sel = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b10_01_00) begin
            errors++;
            $display("FAIL abort_restart_first_bit: got %b expected %b", outs, 6'b10_01_00);
        end
        m1_slave_sel = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b10_01_01) begin
            errors++;
            $display("FAIL abort_restart_addr: got %b expected %b", outs, 6'b10_01_01);
        end
        m1_request = 1'b0;
        tick();
    endtask

    task automatic test_abort_reset();
        m2_request   = 1'b1;
        tick();
        m2_slave_sel = 1'b1;
        tick();
        m2_slave_sel = 1'b0;
        tick();
        checks++;
        if (outs !== 6'b01_10_10) begin
            errors++;
            $display("FAIL rst_abort_m2_busy: got %b expected %b", outs, 6'b01_10_10);
        end
        #2;
        sys_rst = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL rst_abort_async: got %b expected %b", outs, 6'b00_00_00);
        end
        m2_request = 1'b0;
        tick();
        sys_rst = 1'b1;
        tick();
        checks++;
        if (outs !== 6'b00_00_00) begin
            errors++;
            $display("FAIL rst_abort_after_release: got %b expected %b", outs, 6'b00_00_00);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        sys_rst      = 1'b0;
        m1_request   = 1'b0;
        m2_request   = 1'b0;
        m1_slave_sel = 1'b0;
        m2_slave_sel = 1'b0;
        test_reset();
        test_m1_single();
        test_m2_single();
        test_simultaneous();
        test_no_preemption();
        test_abort_addr();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
